// File: rtl/jericalla_if.sv
// Handshake bundle for jericalla_pipe: instruction stream in, result stream out,
// and the side port that preloads registers.
interface jericalla_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int INSTR_W = 3 + 3 * ADDR_W;

    logic [INSTR_W-1:0] instruccion;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  dataOut_jericalla;
    logic               zf_jericalla;
    logic               cf_jericalla;
    logic [ADDR_W-1:0]  rd_out;
    logic               out_valid;
    logic               out_ready;
    logic               ld_we;
    logic [ADDR_W-1:0]  ld_addr;
    logic [DATA_W-1:0]  ld_data;
    logic               ld_ready;

    modport master (
        output instruccion, in_valid, out_ready, ld_we, ld_addr, ld_data,
        input  in_ready, dataOut_jericalla, zf_jericalla, cf_jericalla, rd_out, out_valid, ld_ready
    );

    modport slave (
        input  instruccion, in_valid, out_ready, ld_we, ld_addr, ld_data,
        output in_ready, dataOut_jericalla, zf_jericalla, cf_jericalla, rd_out, out_valid, ld_ready
    );
endinterface

// File: rtl/jericalla_pipe.sv
// Two-stage register-file ALU: operands are resolved (with forwarding) at accept into S1,
// the ALU result lands in the S2 output register and is written back when consumed.
module jericalla_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic      clk_jericalla,
    input  logic      rst_n_jericalla,
    jericalla_if.slave bus
);
    localparam int INSTR_W = 3 + 3 * ADDR_W;
    localparam int DEPTH   = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLT  = 3'd5,
        OP_PASS = 3'd6,
        OP_NOP  = 3'd7
    } op_e;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              zf;
        logic              cf;
    } alu_t;

    // Carry for ADD and borrow for SUB both come from bit DATA_W of the widened result.
    function automatic alu_t alu_f(input op_e op, input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] wide;
        alu_t            r;
        wide  = '0;
        r.res = '0;
        r.cf  = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                r.res = wide[DATA_W-1:0];
                r.cf  = wide[DATA_W];
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                r.res = wide[DATA_W-1:0];
                r.cf  = wide[DATA_W];
            end
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            OP_XOR:  r.res = a ^ b;
            OP_SLT:  r.res = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_PASS: r.res = a;
            default: r.res = '0;
        endcase
        r.zf = (r.res == '0);
        return r;
    endfunction

    logic [DATA_W-1:0] regs [DEPTH];

    op_e               dec_op;
    logic [ADDR_W-1:0] dec_rs1;
    logic [ADDR_W-1:0] dec_rs2;
    logic [ADDR_W-1:0] dec_rd;

    logic              vld_p1;
    op_e               op_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [ADDR_W-1:0] rd_p1;
    alu_t              alu_p1;
    logic              live_p1;

    logic              vld_p2;
    logic [DATA_W-1:0] res_p2;
    logic              zf_p2;
    logic              cf_p2;
    logic [ADDR_W-1:0] rd_p2;

    logic              advance;
    logic              accept;
    logic              wb;
    logic              ld_go;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    assign dec_op  = op_e'(bus.instruccion[INSTR_W-1 -: 3]);
    assign dec_rs1 = bus.instruccion[3*ADDR_W-1 -: ADDR_W];
    assign dec_rs2 = bus.instruccion[2*ADDR_W-1 -: ADDR_W];
    assign dec_rd  = bus.instruccion[ADDR_W-1:0];

    assign alu_p1  = alu_f(op_p1, a_p1, b_p1);
    assign live_p1 = vld_p1 && (op_p1 != OP_NOP);

    assign advance      = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || advance;
    assign accept       = bus.in_valid && bus.in_ready;
    assign wb           = vld_p2 && bus.out_ready;
    assign bus.ld_ready = !wb;
    assign ld_go        = bus.ld_we && !wb;

    // Later assignments override: S1 result beats S2 result beats the register file.
    always_comb begin
        opa = regs[dec_rs1];
        opb = regs[dec_rs2];
        if (vld_p2 && (rd_p2 == dec_rs1)) opa = res_p2;
        if (vld_p2 && (rd_p2 == dec_rs2)) opb = res_p2;
        if (live_p1 && (rd_p1 == dec_rs1)) opa = alu_p1.res;
        if (live_p1 && (rd_p1 == dec_rs2)) opb = alu_p1.res;
    end

    // ---- S1: resolved operands captured at accept ----
    always_ff @(posedge clk_jericalla) begin
        if (!rst_n_jericalla) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (advance) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk_jericalla) begin
        if (accept) begin
            op_p1 <= dec_op;
            a_p1  <= opa;
            b_p1  <= opb;
            rd_p1 <= dec_rd;
        end
    end

    // ---- S2: output register, frozen while the consumer stalls ----
    always_ff @(posedge clk_jericalla) begin
        if (!rst_n_jericalla) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            zf_p2  <= 1'b0;
            cf_p2  <= 1'b0;
            rd_p2  <= '0;
        end else if (advance) begin
            vld_p2 <= live_p1;
            if (live_p1) begin
                res_p2 <= alu_p1.res;
                zf_p2  <= alu_p1.zf;
                cf_p2  <= alu_p1.cf;
                rd_p2  <= rd_p1;
            end
        end
    end

    // ---- Writeback: pipeline result takes the port over a same-cycle load ----
    always_ff @(posedge clk_jericalla) begin
        if (!rst_n_jericalla) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wb) begin
            regs[rd_p2] <= res_p2;
        end else if (ld_go) begin
            regs[bus.ld_addr] <= bus.ld_data;
        end
    end

    assign bus.dataOut_jericalla = res_p2;
    assign bus.zf_jericalla      = zf_p2;
    assign bus.cf_jericalla      = cf_p2;
    assign bus.rd_out            = rd_p2;
    assign bus.out_valid         = vld_p2;
endmodule

// File: doc/jericalla_pipe.md
Name: jericalla_pipe

Overview:
Parametrised, pipelined successor of the single-cycle jericalla datapath. It holds a register file of 2**ADDR_W words of DATA_W bits, a 3-bit-opcode ALU and zero/carry flags. Instructions arrive on a valid/ready stream. Results leave on a valid/ready stream and are written back to the register file. A side load port preloads registers. Instruction format for defaults (18 bits): opcode[17:15], rs1[14:10], rs2[9:5], rd[4:0].

Parameters:
DATA_W, 32, register/ALU data width
ADDR_W, 5, register address width; depth = 2**ADDR_W
INSTR_W, 3+3*ADDR_W, instruction width (derived, never overridden)

Ports:
clk_jericalla  in  1  clock, rising edge
rst_n_jericalla  in  1  synchronous active-low reset
instruccion  in  INSTR_W  {opcode, rs1, rs2, rd}
in_valid  in  1  instruction valid
in_ready  out  1  instruction accepted when in_valid && in_ready
dataOut_jericalla  out  DATA_W  ALU result
zf_jericalla  out  1  result == 0
cf_jericalla  out  1  carry-out (ADD) / borrow (SUB), else 0
rd_out  out  ADDR_W  destination of current result
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
ld_we  in  1  load-port write request
ld_addr  in  ADDR_W  load address
ld_data  in  DATA_W  load data
ld_ready  out  1  load accepted when ld_we && ld_ready

Behaviour:
- Reset (rst_n_jericalla=0 at a rising edge): all register-file words are 0. S1/S2 valid are 0. dataOut, zf, cf and rd_out are 0. out_valid=0. Reset mid-operation discards in-flight instructions without writeback.
- Opcodes: 000 ADD, 001 SUB (rs1-rs2), 010 AND, 011 OR, 100 XOR, 101 SLT (unsigned, result 1/0), 110 PASS (rs1), 111 NOP.
- NOP passes through the pipe but produces no out_valid and no writeback.
- Arithmetic wraps modulo 2**DATA_W. cf = bit DATA_W of the (DATA_W+1)-bit sum; for SUB, cf = 1 when rs1 < rs2 (unsigned).
- Pipeline has two stages:
  - S1 holds opcode, operands and rd; it is captured at the accept edge.
  - S2 is the output register: dataOut, flags, rd_out, out_valid. The ALU is combinational between S1 and S2.
- advance = !out_valid || out_ready. S2 loads from S1 when advance. in_ready = !s1_valid || advance.
- Latency: an instruction accepted at edge E0 shows out_valid after edge E1 when there is no backpressure. Throughput is 1 instruction per cycle.
- Writeback: reg[rd_out] <= dataOut at the edge where out_valid && out_ready. A held result (out_ready=0) is never written twice and never lost; outputs stay stable while held.
- Operand forwarding at accept, highest priority first:
  1. ALU output of a valid non-NOP S1 whose rd matches.
  2. S2 whose rd_out matches and out_valid=1.
  3. Register file.
- Back-to-back dependent instructions therefore see the correct values with no bubbles.
- Load port: ld_ready = !(out_valid && out_ready). The pipeline writeback wins over a load in the same cycle. An accepted load writes at that edge. A same-edge instruction read of ld_addr sees the old value; there is no bypass from the load port.
- A load to a register already read by an in-flight instruction does not affect that instruction.
- rs1 == rs2 == rd is legal. Register 0 is an ordinary register, not hardwired to zero.

Test Plan:
1. Reset, then load r4=7, r1=7, r5=9. Issue ADD rs1=4 rs2=1 rd=0 (18'b000001000000100000) -> out_valid after 2 edges: dataOut=14, zf=0, cf=0, rd_out=0; then r0=14.
2. Back-to-back dependent instructions: ADD r0=r4+r1, then SUB rs1=0 rs2=0 rd=2 immediately after -> second result 0 with zf=1 and cf=0. Proves forwarding from S1.
3. Load r6=32'hFFFFFFFF and r1=1; ADD 6,1 -> 3 -> dataOut=0, zf=1, cf=1. Then SLT 1,6 -> 7 -> dataOut=1.
4. Backpressure: hold out_ready=0 for 3 cycles with 3 instructions offered. S1 and S2 fill, in_ready drops and dataOut stays stable. Release -> results arrive in order, each written exactly once.
5. Drive ld_we in the same cycle as a writeback to the same address -> ld_ready=0 and the writeback value persists. Retry the load next cycle -> load value wins.
6. Assert reset with 2 instructions in flight -> the next cycle shows out_valid=0 and no register changes except clearing to 0. NOP input -> no out_valid.
